// File: rtl/sram_access_arbiter.sv
// ============================================================================
// Module   : sram_access_arbiter
// Brief    : Round-robin req/ack arbiter sequencing a 16-bit async SRAM with
//            fixed SETUP / ACCESS / DONE phases and registered strobes.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sram_access_arbiter #(
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Reset_N,
    input  logic              Cpu_Req,
    input  logic              Cpu_Write,
    input  logic [ADDR_W-1:0] Cpu_Addr,
    input  logic [DATA_W-1:0] Cpu_WData,
    input  logic [1:0]        Cpu_ByteEn,
    output logic              Cpu_Ack,
    output logic [DATA_W-1:0] Cpu_RData,
    input  logic              Dbg_Req,
    input  logic              Dbg_Write,
    input  logic [ADDR_W-1:0] Dbg_Addr,
    input  logic [DATA_W-1:0] Dbg_WData,
    input  logic [1:0]        Dbg_ByteEn,
    output logic              Dbg_Ack,
    output logic [DATA_W-1:0] Dbg_RData,
    output logic              SRAM_CE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_WE_N,
    output logic              SRAM_LB_N,
    output logic              SRAM_UB_N,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic [DATA_W-1:0] Sram_WData,
    output logic              Sram_WData_Oe,
    input  logic [DATA_W-1:0] Sram_RData,
    output logic              Busy
);

    localparam logic [3:0] c_WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_write;
    logic [1:0]        r_be;
    logic              r_sel_dbg;
    logic              r_last_dbg;
    logic [3:0]        r_cnt;
    logic              r_ce_n, r_oe_n, r_we_n, r_lb_n, r_ub_n;
    logic [ADDR_W-1:0] r_sram_addr;
    logic [DATA_W-1:0] r_sram_wdata;
    logic              r_wdata_oe;
    logic              r_cpu_ack, r_dbg_ack;
    logic [DATA_W-1:0] r_cpu_rdata, r_dbg_rdata;

    logic              w_grant_cpu, w_grant_dbg, w_any_req;
    logic              w_write;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic [1:0]        w_be;

    // When both request, the port that was not served last wins.
    assign w_grant_cpu = Cpu_Req && (!Dbg_Req || r_last_dbg);
    assign w_grant_dbg = Dbg_Req && !w_grant_cpu;
    assign w_any_req   = Cpu_Req || Dbg_Req;
    assign w_write     = w_grant_dbg ? Dbg_Write  : Cpu_Write;
    assign w_addr      = w_grant_dbg ? Dbg_Addr   : Cpu_Addr;
    assign w_wdata     = w_grant_dbg ? Dbg_WData  : Cpu_WData;
    assign w_be        = w_grant_dbg ? Dbg_ByteEn : Cpu_ByteEn;

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            r_state      <= S_IDLE;
            r_write      <= 1'b0;
            r_be         <= 2'b00;
            r_sel_dbg    <= 1'b0;
            r_last_dbg   <= 1'b1;
            r_cnt        <= 4'd0;
            r_ce_n       <= 1'b1;
            r_oe_n       <= 1'b1;
            r_we_n       <= 1'b1;
            r_lb_n       <= 1'b1;
            r_ub_n       <= 1'b1;
            r_sram_addr  <= '0;
            r_sram_wdata <= '0;
            r_wdata_oe   <= 1'b0;
            r_cpu_ack    <= 1'b0;
            r_dbg_ack    <= 1'b0;
            r_cpu_rdata  <= '0;
            r_dbg_rdata  <= '0;
        end else begin
            r_cpu_ack <= 1'b0;
            r_dbg_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_state      <= S_SETUP;
                        r_sel_dbg    <= w_grant_dbg;
                        r_last_dbg   <= w_grant_dbg;
                        r_write      <= w_write;
                        r_be         <= w_be;
                        r_sram_addr  <= w_addr;
                        r_sram_wdata <= w_wdata;
                        r_ce_n       <= 1'b0;
                        r_oe_n       <= w_write;
                        r_lb_n       <= w_write;
                        r_ub_n       <= w_write;
                        r_wdata_oe   <= w_write;
                    end
                end
                S_SETUP: begin
                    r_state <= S_ACCESS;
                    r_cnt   <= c_WAIT_LOAD;
                    if (r_write) begin
                        r_we_n <= 1'b0;
                        r_lb_n <= ~r_be[0];
                        r_ub_n <= ~r_be[1];
                    end
                end
                S_ACCESS: begin
                    if (r_cnt == 4'd0) begin
                        r_state   <= S_DONE;
                        r_we_n    <= 1'b1;
                        r_oe_n    <= 1'b1;
                        r_lb_n    <= 1'b1;
                        r_ub_n    <= 1'b1;
                        r_cpu_ack <= !r_sel_dbg;
                        r_dbg_ack <= r_sel_dbg;
                        if (!r_write) begin
                            if (r_sel_dbg) begin
                                r_dbg_rdata <= Sram_RData;
                            end else begin
                                r_cpu_rdata <= Sram_RData;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    // Chip enable and write data are held through this cycle.
                    r_state    <= S_IDLE;
                    r_ce_n     <= 1'b1;
                    r_wdata_oe <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign Cpu_Ack       = r_cpu_ack;
    assign Dbg_Ack       = r_dbg_ack;
    assign Cpu_RData     = r_cpu_rdata;
    assign Dbg_RData     = r_dbg_rdata;
    assign SRAM_CE_N     = r_ce_n;
    assign SRAM_OE_N     = r_oe_n;
    assign SRAM_WE_N     = r_we_n;
    assign SRAM_LB_N     = r_lb_n;
    assign SRAM_UB_N     = r_ub_n;
    assign SRAM_ADDR     = r_sram_addr;
    assign Sram_WData    = r_sram_wdata;
    assign Sram_WData_Oe = r_wdata_oe;
    assign Busy          = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_sram_access_arbiter.sv
// ============================================================================
// Module   : tb_sram_access_arbiter
// Brief    : Scoreboard bench for sram_access_arbiter with a behavioural SRAM.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sram_access_arbiter;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 16;
    localparam int WAIT   = 2;

    logic              Clk = 1'b0;
    logic              Reset_N;
    logic              Cpu_Req, Cpu_Write, Dbg_Req, Dbg_Write;
    logic [ADDR_W-1:0] Cpu_Addr, Dbg_Addr;
    logic [DATA_W-1:0] Cpu_WData, Dbg_WData;
    logic [1:0]        Cpu_ByteEn, Dbg_ByteEn;
    logic              Cpu_Ack, Dbg_Ack;
    logic [DATA_W-1:0] Cpu_RData, Dbg_RData;
    logic              SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N;
    logic [ADDR_W-1:0] SRAM_ADDR;
    logic [DATA_W-1:0] Sram_WData, Sram_RData;
    logic              Sram_WData_Oe, Busy;

    always #5 Clk = ~Clk;

    sram_access_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_CYCLES(WAIT)) dut (
        .Clk(Clk), .Reset_N(Reset_N),
        .Cpu_Req(Cpu_Req), .Cpu_Write(Cpu_Write), .Cpu_Addr(Cpu_Addr),
        .Cpu_WData(Cpu_WData), .Cpu_ByteEn(Cpu_ByteEn), .Cpu_Ack(Cpu_Ack), .Cpu_RData(Cpu_RData),
        .Dbg_Req(Dbg_Req), .Dbg_Write(Dbg_Write), .Dbg_Addr(Dbg_Addr),
        .Dbg_WData(Dbg_WData), .Dbg_ByteEn(Dbg_ByteEn), .Dbg_Ack(Dbg_Ack), .Dbg_RData(Dbg_RData),
        .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N),
        .SRAM_LB_N(SRAM_LB_N), .SRAM_UB_N(SRAM_UB_N), .SRAM_ADDR(SRAM_ADDR),
        .Sram_WData(Sram_WData), .Sram_WData_Oe(Sram_WData_Oe), .Sram_RData(Sram_RData),
        .Busy(Busy)
    );

    // Behavioural asynchronous SRAM (low 10 address bits decoded).
    logic [15:0] sram_mem [0:1023];
    assign Sram_RData = (!SRAM_CE_N && !SRAM_OE_N) ? sram_mem[SRAM_ADDR[9:0]] : 16'hDEAD;
    always @(posedge Clk) begin
        if (!SRAM_CE_N && !SRAM_WE_N && Sram_WData_Oe) begin
            if (!SRAM_LB_N) sram_mem[SRAM_ADDR[9:0]][7:0]  <= Sram_WData[7:0];
            if (!SRAM_UB_N) sram_mem[SRAM_ADDR[9:0]][15:8] <= Sram_WData[15:8];
        end
    end

    // Reference model: a plain byte-enabled memory plus expected-data queues.
    logic [15:0] ref_mem [0:1023];
    logic [15:0] cpu_q[$];
    logic [15:0] dbg_q[$];
    int          order_q[$];
    logic [15:0] exp_last [2];
    logic [15:0] cpu_rd_model, dbg_rd_model;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    task automatic ref_write(input logic [19:0] a, input logic [15:0] d, input logic [1:0] be);
        if (be[0]) ref_mem[a[9:0]][7:0]  = d[7:0];
        if (be[1]) ref_mem[a[9:0]][15:8] = d[15:8];
    endtask

    // Monitor: strobe rules every cycle, scoreboard pop on every Ack.
    logic prev_cpu_ack = 1'b0, prev_dbg_ack = 1'b0;
    int   we_low_cnt = 0;
    logic last_lb = 1'b1, last_ub = 1'b1;
    logic [3:0] viol;

    always @(negedge Clk) begin
        if (Reset_N === 1'b1) begin
            viol = {Sram_WData_Oe && !SRAM_OE_N,
                    !SRAM_OE_N && !SRAM_WE_N,
                    SRAM_CE_N && (!SRAM_OE_N || !SRAM_WE_N),
                    !Busy && !SRAM_CE_N};
            check("strobe_rules", {28'd0, viol}, 32'd0);
            if (!SRAM_WE_N) begin
                we_low_cnt++;
                last_lb = SRAM_LB_N;
                last_ub = SRAM_UB_N;
            end
            if (Cpu_Ack) begin
                check("cpu_ack_pulse", {31'd0, prev_cpu_ack}, 32'd0);
                check("ack_exclusive", {31'd0, Dbg_Ack}, 32'd0);
                if (cpu_q.size() == 0) flag("cpu_unexpected_ack");
                else begin
                    cpu_rd_model = cpu_q.pop_front();
                    check("cpu_rdata", {16'd0, Cpu_RData}, {16'd0, cpu_rd_model});
                end
                check("dbg_rdata_hold", {16'd0, Dbg_RData}, {16'd0, dbg_rd_model});
                order_q.push_back(0);
            end
            if (Dbg_Ack) begin
                check("dbg_ack_pulse", {31'd0, prev_dbg_ack}, 32'd0);
                if (dbg_q.size() == 0) flag("dbg_unexpected_ack");
                else begin
                    dbg_rd_model = dbg_q.pop_front();
                    check("dbg_rdata", {16'd0, Dbg_RData}, {16'd0, dbg_rd_model});
                end
                check("cpu_rdata_hold", {16'd0, Cpu_RData}, {16'd0, cpu_rd_model});
                order_q.push_back(1);
            end
        end
        prev_cpu_ack = Cpu_Ack;
        prev_dbg_ack = Dbg_Ack;
    end

    // One transaction on a port; lat = cycles from request sampling to Ack.
    task automatic xfer(input bit dbg, input logic wr, input logic [19:0] a,
                        input logic [15:0] d, input logic [1:0] be, output int lat);
        logic [15:0] e;
        @(posedge Clk); #1;
        if (dbg) begin
            Dbg_Req = 1'b1; Dbg_Write = wr; Dbg_Addr = a; Dbg_WData = d; Dbg_ByteEn = be;
        end else begin
            Cpu_Req = 1'b1; Cpu_Write = wr; Cpu_Addr = a; Cpu_WData = d; Cpu_ByteEn = be;
        end
        if (wr) ref_write(a, d, be);
        else exp_last[dbg] = ref_mem[a[9:0]];
        e = exp_last[dbg];
        if (dbg) dbg_q.push_back(e);
        else     cpu_q.push_back(e);
        lat = 0;
        @(negedge Clk);
        while (!(dbg ? Dbg_Ack : Cpu_Ack) && lat < 200) begin
            @(negedge Clk);
            lat++;
        end
        if (!(dbg ? Dbg_Ack : Cpu_Ack)) flag(dbg ? "dbg_ack_timeout" : "cpu_ack_timeout");
        @(posedge Clk); #1;
        if (dbg) Dbg_Req = 1'b0;
        else     Cpu_Req = 1'b0;
    endtask

    task automatic rand_traffic(input bit dbg, input int n);
        int lat;
        for (int i = 0; i < n; i++) begin
            logic        wr;
            logic [19:0] a;
            logic [15:0] d;
            logic [1:0]  be;
            wr = 1'($urandom_range(0, 1));
            a  = (dbg ? 20'h00200 : 20'h00100) + 20'($urandom_range(0, 15));
            d  = 16'($urandom);
            be = 2'($urandom_range(0, 3));
            xfer(dbg, wr, a, d, be, lat);
            repeat ($urandom_range(0, 2)) @(posedge Clk);
        end
    endtask

    task automatic clear_models();
        cpu_q.delete();
        dbg_q.delete();
        order_q.delete();
        exp_last[0] = 16'h0; exp_last[1] = 16'h0;
        cpu_rd_model = 16'h0; dbg_rd_model = 16'h0;
    endtask

    task automatic check_reset_state();
        check("rst_ce_n",  {31'd0, SRAM_CE_N}, 32'd1);
        check("rst_oe_n",  {31'd0, SRAM_OE_N}, 32'd1);
        check("rst_we_n",  {31'd0, SRAM_WE_N}, 32'd1);
        check("rst_lb_ub", {30'd0, SRAM_LB_N, SRAM_UB_N}, 32'd3);
        check("rst_addr",  {12'd0, SRAM_ADDR}, 32'd0);
        check("rst_wdata", {16'd0, Sram_WData}, 32'd0);
        check("rst_oe",    {31'd0, Sram_WData_Oe}, 32'd0);
        check("rst_acks",  {30'd0, Cpu_Ack, Dbg_Ack}, 32'd0);
        check("rst_rdata", {Cpu_RData, Dbg_RData}, 32'd0);
        check("rst_busy",  {31'd0, Busy}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, cyc;
        for (int i = 0; i < 1024; i++) begin
            sram_mem[i] = 16'h0;
            ref_mem[i]  = 16'h0;
        end
        clear_models();
        Reset_N = 1'b0;
        Cpu_Req = 0; Cpu_Write = 0; Cpu_Addr = '0; Cpu_WData = '0; Cpu_ByteEn = 2'b00;
        Dbg_Req = 0; Dbg_Write = 0; Dbg_Addr = '0; Dbg_WData = '0; Dbg_ByteEn = 2'b00;
        #22;
        check_reset_state();
        @(posedge Clk); #1;
        Reset_N = 1'b1;

        // Both held continuously from reset: CPU first, then strict alternation.
        for (int i = 0; i < 4; i++) begin
            cpu_q.push_back(ref_mem[10'h050]);
            dbg_q.push_back(ref_mem[10'h060]);
        end
        @(posedge Clk); #1;
        Cpu_Req = 1; Cpu_Write = 0; Cpu_Addr = 20'h00050;
        Dbg_Req = 1; Dbg_Write = 0; Dbg_Addr = 20'h00060;
        cyc = 0;
        while (order_q.size() < 8 && cyc < 400) begin
            @(posedge Clk);
            cyc++;
        end
        #1;
        Cpu_Req = 0; Dbg_Req = 0;
        if (order_q.size() < 8) flag("alternation_timeout");
        else for (int i = 0; i < 8; i++) check("grant_order", order_q[i], i % 2);
        repeat (4) @(posedge Clk);

        // CPU write: WE low for WAIT cycles and Ack WAIT+2 cycles after sampling.
        we_low_cnt = 0;
        xfer(0, 1, 20'h00030, 16'hBEEF, 2'b11, lat);
        check("write_latency", lat, WAIT + 2);
        check("we_low_cycles", we_low_cnt, WAIT);
        xfer(0, 0, 20'h00030, 16'h0, 2'b00, lat);
        check("read_latency", lat, WAIT + 2);
        check("cpu_read_beef", {16'd0, Cpu_RData}, 32'hBEEF);

        // Dbg read while CPU holds BEEF.
        xfer(1, 1, 20'h00040, 16'h5A5A, 2'b11, lat);
        xfer(1, 0, 20'h00040, 16'h0, 2'b00, lat);
        check("dbg_read_5a5a", {16'd0, Dbg_RData}, 32'h5A5A);
        check("cpu_rdata_kept", {16'd0, Cpu_RData}, 32'hBEEF);

        // Low-byte-only write.
        xfer(1, 1, 20'h00030, 16'h1234, 2'b01, lat);
        check("lb_ub_in_access", {30'd0, last_lb, last_ub}, 32'd1);
        xfer(1, 0, 20'h00030, 16'h0, 2'b00, lat);
        check("dbg_read_be34", {16'd0, Dbg_RData}, 32'hBE34);

        // ByteEn=00 write leaves memory untouched but still acks.
        xfer(0, 1, 20'h00030, 16'hFFFF, 2'b00, lat);
        check("be00_lanes", {30'd0, last_lb, last_ub}, 32'd3);
        xfer(0, 0, 20'h00030, 16'h0, 2'b00, lat);
        check("cpu_read_after_be00", {16'd0, Cpu_RData}, 32'hBE34);

        // Address changed by the CPU mid-transaction must not reach the SRAM.
        fork
            xfer(0, 0, 20'h00040, 16'h0, 2'b00, lat);
            begin
                cyc = 0;
                do begin @(negedge Clk); cyc++; end while (!Busy && cyc < 50);
                @(posedge Clk); #1;
                Cpu_Addr = 20'h00777;
                cyc = 0;
                do begin
                    @(negedge Clk);
                    cyc++;
                    if (!SRAM_CE_N) check("addr_latched", {12'd0, SRAM_ADDR}, 32'h00040);
                end while (!Cpu_Ack && cyc < 50);
            end
        join
        check("cpu_read_latched_addr", {16'd0, Cpu_RData}, 32'h5A5A);

        // Concurrent randomized traffic in disjoint address windows.
        fork
            rand_traffic(0, 30);
            rand_traffic(1, 30);
        join
        repeat (4) @(posedge Clk);
        check("cpu_q_drained", cpu_q.size(), 0);
        check("dbg_q_drained", dbg_q.size(), 0);

        // Asynchronous reset in the middle of a write ACCESS phase.
        @(posedge Clk); #1;
        Cpu_Req = 1; Cpu_Write = 1; Cpu_Addr = 20'h003F0; Cpu_WData = 16'hAAAA; Cpu_ByteEn = 2'b11;
        cyc = 0;
        do begin @(negedge Clk); cyc++; end while (SRAM_WE_N && cyc < 20);
        if (SRAM_WE_N) flag("reset_test_no_we");
        #2;
        Reset_N = 1'b0;
        #1;
        check("rst_mid_we_n", {31'd0, SRAM_WE_N}, 32'd1);
        check("rst_mid_ce_n", {31'd0, SRAM_CE_N}, 32'd1);
        check("rst_mid_oe",   {31'd0, Sram_WData_Oe}, 32'd0);
        check("rst_mid_busy", {31'd0, Busy}, 32'd0);
        Cpu_Req = 0;
        clear_models();
        @(posedge Clk); #1;
        check_reset_state();
        Reset_N = 1'b1;
        repeat (10) @(negedge Clk);
        xfer(0, 0, 20'h00030, 16'h0, 2'b00, lat);
        check("post_reset_read", {16'd0, Cpu_RData}, 32'hBE34);
        repeat (3) @(posedge Clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
